// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Stall/flush sequencer for the IF/ID/EX registers of the 5-stage core.
// Resolves load-use hazards, EX branch redirects and multi-cycle FFT
// coprocessor operations with one RUN/COP_WAIT state machine, and
// guards the coprocessor handshake with a timeout watchdog.
//
// Optional feature: define STALL_PERF_CNT_EN to build the saturating
// stall_cycles performance counter; otherwise stall_cycles reads 0.
//
// Reset is synchronous and active-high. While rst is high every control
// output is forced low, so nothing reaches the pipeline until the FSM
// is back in RUN.

module pipeline_stall_ctrl #(
    parameter int              REG_AW      = 5,
    parameter int              TO_W        = 8,
    parameter logic [TO_W-1:0] COP_TIMEOUT = 8'd200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ifid_rs1_addr,
    input  logic [REG_AW-1:0] ifid_rs2_addr,
    input  logic [REG_AW-1:0] idex_rd_addr,
    input  logic              idex_mem_rena,
    input  logic              ex_branch_taken,
    input  logic              id_cop_req,
    input  logic              cop_ready,
    input  logic              cop_done,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              cop_issue,
    output logic              cop_busy,
    output logic              cop_err,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_COP_WAIT = 1'b1
    } state_t;

    // Last counter value before the watchdog fires.
    localparam logic [TO_W-1:0] TO_LAST = COP_TIMEOUT - {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          state_next_s;
    logic [TO_W-1:0] to_cnt_r;
    logic [TO_W-1:0] to_cnt_next_s;

    logic load_use_s;
    logic timeout_hit_s;
    logic pc_hold_s;
    logic ifid_hold_s;
    logic ifid_flush_s;
    logic idex_bubble_s;
    logic cop_issue_s;
    logic cop_busy_s;
    logic cop_err_s;

    // A load writing x0 never creates a dependency.
    assign load_use_s = idex_mem_rena
                      & (idex_rd_addr != {REG_AW{1'b0}})
                      & ((idex_rd_addr == ifid_rs1_addr) | (idex_rd_addr == ifid_rs2_addr));

    assign timeout_hit_s = (to_cnt_r == TO_LAST);

    // Next-state and same-cycle pipeline controls from state and inputs.
    always_comb begin
        state_next_s  = state_r;
        to_cnt_next_s = to_cnt_r;
        pc_hold_s     = 1'b0;
        ifid_hold_s   = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        cop_issue_s   = 1'b0;
        cop_busy_s    = 1'b0;
        cop_err_s     = 1'b0;
        if (rst) begin
            state_next_s  = ST_RUN;
            to_cnt_next_s = {TO_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        // Redirect wins: squash the wrong-path fetch and ID.
                        ifid_flush_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else if (load_use_s) begin
                        pc_hold_s     = 1'b1;
                        ifid_hold_s   = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else if (id_cop_req && !cop_ready) begin
                        pc_hold_s     = 1'b1;
                        ifid_hold_s   = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else if (id_cop_req && cop_ready) begin
                        cop_issue_s   = 1'b1;
                        pc_hold_s     = 1'b1;
                        ifid_hold_s   = 1'b1;
                        idex_bubble_s = 1'b1;
                        to_cnt_next_s = {TO_W{1'b0}};
                        state_next_s  = ST_COP_WAIT;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_COP_WAIT: begin
                    // EX only holds bubbles here, so branches cannot occur.
                    cop_busy_s    = 1'b1;
                    to_cnt_next_s = to_cnt_r + TO_ONE;
                    if (cop_done) begin
                        // Cop instruction advances to EX this cycle.
                        state_next_s = ST_RUN;
                    end else if (timeout_hit_s) begin
                        cop_err_s    = 1'b1;
                        state_next_s = ST_RUN;
                    end else begin
                        pc_hold_s     = 1'b1;
                        ifid_hold_s   = 1'b1;
                        idex_bubble_s = 1'b1;
                    end
                end
                default: begin
                    state_next_s  = ST_RUN;
                    to_cnt_next_s = {TO_W{1'b0}};
                end
            endcase
        end
    end

    // State register and watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_RUN;
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            to_cnt_r <= to_cnt_next_s;
        end
    end

    assign pc_hold     = pc_hold_s;
    assign ifid_hold   = ifid_hold_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_bubble = idex_bubble_s;
    assign cop_issue   = cop_issue_s;
    assign cop_busy    = cop_busy_s;
    assign cop_err     = cop_err_s;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Count held-PC cycles, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (pc_hold_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cycles = stall_cnt_r;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: the driver pushes the
// hand-computed control vector for each cycle, the monitor pops and
// compares on the falling edge. Expected stall_cycles follows the
// STALL_PERF_CNT_EN build option.

module tb_pipeline_stall_ctrl;

    // Control vector order: {pc_hold, ifid_hold, ifid_flush, idex_bubble,
    //                        cop_issue, cop_busy, cop_err}
    localparam logic [6:0] C_ZERO  = 7'b0000000;
    localparam logic [6:0] C_HOLD  = 7'b1101000;
    localparam logic [6:0] C_FLUSH = 7'b0011000;
    localparam logic [6:0] C_ISSUE = 7'b1101100;
    localparam logic [6:0] C_WAIT  = 7'b1101010;
    localparam logic [6:0] C_DONE  = 7'b0000010;
    localparam logic [6:0] C_ERR   = 7'b0000011;

    typedef struct {
        string       name;
        logic [6:0]  ctl;
        logic [31:0] stall;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  ifid_rs1_addr;
    logic [4:0]  ifid_rs2_addr;
    logic [4:0]  idex_rd_addr;
    logic        idex_mem_rena;
    logic        ex_branch_taken;
    logic        id_cop_req;
    logic        cop_ready;
    logic        cop_done;
    logic        pc_hold;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        cop_issue;
    logic        cop_busy;
    logic        cop_err;
    logic [31:0] stall_cycles;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [6:0]  mon_act;
    int          vectors;
    int          miscompares;
    logic [31:0] stall_model;

    pipeline_stall_ctrl #(
        .REG_AW      (5),
        .TO_W        (8),
        .COP_TIMEOUT (8'd200)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ifid_rs1_addr   (ifid_rs1_addr),
        .ifid_rs2_addr   (ifid_rs2_addr),
        .idex_rd_addr    (idex_rd_addr),
        .idex_mem_rena   (idex_mem_rena),
        .ex_branch_taken (ex_branch_taken),
        .id_cop_req      (id_cop_req),
        .cop_ready       (cop_ready),
        .cop_done        (cop_done),
        .pc_hold         (pc_hold),
        .ifid_hold       (ifid_hold),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .cop_issue       (cop_issue),
        .cop_busy        (cop_busy),
        .cop_err         (cop_err),
        .stall_cycles    (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic mem, input logic br, input logic req,
                          input logic rdy, input logic done);
        ifid_rs1_addr   = rs1;
        ifid_rs2_addr   = rs2;
        idex_rd_addr    = rd;
        idex_mem_rena   = mem;
        ex_branch_taken = br;
        id_cop_req      = req;
        cop_ready       = rdy;
        cop_done        = done;
    endtask

    task automatic set_idle();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic drive(input string nm, input logic [6:0] ctl);
        exp_t e;
        e.name = nm;
        e.ctl  = ctl;
`ifdef STALL_PERF_CNT_EN
        e.stall = stall_model;
`else
        e.stall = 32'd0;
`endif
        exp_q.push_back(e);
        if (rst) begin
            stall_model = 32'd0;
        end else if (ctl[6]) begin
            stall_model = stall_model + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = {pc_hold, ifid_hold, ifid_flush, idex_bubble, cop_issue, cop_busy, cop_err};
            vectors = vectors + 1;
            if ((mon_act !== mon_e.ctl) || (stall_cycles !== mon_e.stall)) begin
                miscompares = miscompares + 1;
                $display("FAIL %s: got ctl=%b stall_cycles=%0d, expected ctl=%b stall_cycles=%0d",
                         mon_e.name, mon_act, stall_cycles, mon_e.ctl, mon_e.stall);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        stall_model = 32'd0;
        rst         = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        drive("reset0", C_ZERO);
        drive("reset1", C_ZERO);
        rst = 1'b0;
        drive("idle_after_reset", C_ZERO);

        // Load x5 in EX, ID reads rs1=x5: exactly one stall cycle
        set_in(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("load_use_rs1", C_HOLD);
        set_in(5'd5, 5'd9, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("load_use_cleared", C_ZERO);

        // Load to x0 never stalls
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("load_x0_no_stall", C_ZERO);

        // rs2 match stalls; no match does not
        set_in(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("load_use_rs2", C_HOLD);
        set_in(5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("load_no_match", C_ZERO);
        // Matching non-load does not stall
        set_in(5'd7, 5'd4, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("alu_match_no_stall", C_ZERO);

        // Branch beats load-use and cop request
        set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive("branch_priority", C_FLUSH);
        set_idle();
        drive("after_branch_run", C_ZERO);

        // Cop not ready for 3 cycles, then issue (cop_done in issue cycle ignored)
        for (int i = 0; i < 3; i++) begin
            set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            drive($sformatf("cop_not_ready_%0d", i), C_HOLD);
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive("cop_issue", C_ISSUE);
        for (int i = 0; i < 10; i++) begin
            // Request still present and a stray branch: both ignored
            set_in(5'd0, 5'd0, 5'd0, 1'b0, (i == 4) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0);
            drive($sformatf("cop_wait_%0d", i), C_WAIT);
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive("cop_done_release", C_DONE);
        set_idle();
        drive("run_after_done", C_ZERO);

        // Timeout: no cop_done, error in 200th wait cycle
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive("to_issue", C_ISSUE);
        set_idle();
        for (int i = 0; i < 199; i++) begin
            drive($sformatf("to_wait_%0d", i), C_WAIT);
        end
        drive("to_cop_err", C_ERR);
        drive("to_run_after_err", C_ZERO);

        // Reset 5 cycles into COP_WAIT
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive("rst_issue", C_ISSUE);
        set_idle();
        for (int i = 0; i < 5; i++) begin
            drive($sformatf("rst_wait_%0d", i), C_WAIT);
        end
        rst = 1'b1;
        drive("rst_mid_wait", C_ZERO);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            drive($sformatf("post_rst_idle_%0d", i), C_ZERO);
        end

        // Fresh op after reset: counter restarted, done on first wait
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive("post_rst_issue", C_ISSUE);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive("post_rst_done", C_DONE);
        set_idle();
        drive("final_idle", C_ZERO);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() != 0) begin
                @(posedge clk);
            end
        end
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
